alu32_result_stage: RTL and testbench

Registered output stage directly downstream of the 32-bit ALU datapath. It accepts each ALU result with its carry and overflow bits through a valid/ready handshake. It derives the zero flag through an internal `zero32` instance and the negative flag from bit 31, then buffers {result, flags} in a small FIFO. The FIFO feeds the writeback/branch logic.

---
 rtl/alu32_result_stage.sv | 122 ++++++++++++
 tb/tb_alu32_result_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu32_result_stage.sv
// ALU result stage: tags each ALU result with {N,Z,C,V} and queues it in a small FIFO.
// Optional sticky overflow flag is enabled by defining ALU32_STICKY_OVF_EN.

module zero32 (
  input  logic [31:0] value,
  output logic        is_zero
);
  assign is_zero = (value == 32'd0);
endmodule

module alu32_result_stage #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_carry,
  input  logic                       in_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_sticky,
  output logic                       sticky_v
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      res_mem [DEPTH];
  logic [3:0]       flg_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             push;
  logic             pop;
  logic             res_zero;
  logic [3:0]       in_flags;

  zero32 u_zero32 (
    .value   (in_result),
    .is_zero (res_zero)
  );

  assign in_flags  = {in_result[31], res_zero, in_carry, in_overflow};

  // Handshake readiness decodes only from registered occupancy.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != CW'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= 32'd0;
        flg_mem[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          res_mem[i] <= in_result;
          flg_mem[i] <= in_flags;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_result = res_mem[rd_ptr_reg];
  assign out_flags  = flg_mem[rd_ptr_reg];
  assign count      = count_reg;

`ifdef ALU32_STICKY_OVF_EN
  logic sticky_reg;

  // An overflow push in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else if (push && in_overflow) begin
      sticky_reg <= 1'b1;
    end else if (clr_sticky) begin
      sticky_reg <= 1'b0;
    end
  end

  assign sticky_v = sticky_reg;
`else
  logic sticky_unused;

  assign sticky_unused = clr_sticky;
  assign sticky_v      = 1'b0;
`endif

endmodule

// File: tb/tb_alu32_result_stage.sv
// Directed self-checking bench for alu32_result_stage (DEPTH = 4).
// Sticky expectations follow ALU32_STICKY_OVF_EN.

module tb_alu32_result_stage;

  localparam int DEPTH = 4;
`ifdef ALU32_STICKY_OVF_EN
  localparam logic STICKY_EXP = 1'b1;
`else
  localparam logic STICKY_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic        clr_sticky;
  logic        sticky_v;

  int checks = 0;
  int errors = 0;

  alu32_result_stage #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .count       (count),
    .clr_sticky  (clr_sticky),
    .sticky_v    (sticky_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] r, input logic c, input logic o);
    in_valid    = v;
    in_result   = r;
    in_carry    = c;
    in_overflow = o;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    #23;
    rst_n = 1'b1;
    cyc();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_v), 32'd0);

    // Single transfer of a zero result with carry
    set_in(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    cyc();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_result", out_result, 32'h0);
    chk("t1_flags", 32'(out_flags), 32'b0110);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t1_count_after", 32'(count), 32'd0);
    chk("t1_out_valid_after", 32'(out_valid), 32'd0);

    // Flag derivation
    set_in(1'b1, 32'h8000_0000, 1'b0, 1'b1); cyc();
    set_in(1'b1, 32'h0000_0001, 1'b0, 1'b0); cyc();
    set_in(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0); cyc();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t2_count", 32'(count), 32'd3);
    chk("t2_sticky", 32'(sticky_v), 32'(STICKY_EXP));
    chk("t2_res0", out_result, 32'h8000_0000);
    chk("t2_flg0", 32'(out_flags), 32'b1001);
    out_ready = 1'b1; cyc();
    chk("t2_res1", out_result, 32'h0000_0001);
    chk("t2_flg1", 32'(out_flags), 32'b0000);
    cyc();
    chk("t2_res2", out_result, 32'hFFFF_FFFF);
    chk("t2_flg2", 32'(out_flags), 32'b1010);
    cyc();
    out_ready = 1'b0;
    chk("t2_count_end", 32'(count), 32'd0);
    chk("t2_sticky_pop", 32'(sticky_v), 32'(STICKY_EXP));

    // Fill and backpressure
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'h1111_0000 + 32'(i), 1'b0, 1'b0);
      cyc();
    end
    chk("t3_count_full", 32'(count), 32'd4);
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    set_in(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc();
    chk("t3_blocked_count", 32'(count), 32'd4);
    chk("t3_blocked_head", out_result, 32'h1111_0000);
    // Full-cycle push/pop: pop only, then the held push is accepted
    out_ready = 1'b1;
    chk("t3_head0", out_result, 32'h1111_0000);
    cyc();
    chk("t3_fullpop_count", 32'(count), 32'd3);
    chk("t3_head1", out_result, 32'h1111_0001);
    cyc();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t3_pushpop_count", 32'(count), 32'd3);
    chk("t3_head2", out_result, 32'h1111_0002);
    cyc();
    chk("t3_head3", out_result, 32'h1111_0003);
    cyc();
    chk("t3_head4", out_result, 32'hDEAD_BEEF);
    chk("t3_flg4", 32'(out_flags), 32'b1000);
    cyc();
    out_ready = 1'b0;
    chk("t3_drained", 32'(count), 32'd0);

    // Simultaneous push/pop at count = 2, across pointer wrap
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 32'hB000_0000 + 32'(k + 2), 1'b0, 1'b0);
      chk($sformatf("t4_head%0d", k), out_result, 32'hB000_0000 + 32'(k));
      cyc();
      chk($sformatf("t4_count%0d", k), 32'(count), 32'd2);
    end
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t4_tail0", out_result, 32'hB000_000A);
    cyc();
    chk("t4_tail1", out_result, 32'hB000_000B);
    cyc();
    out_ready = 1'b0;
    chk("t4_empty", 32'(count), 32'd0);

    // Sticky overflow
    clr_sticky = 1'b1; cyc(); clr_sticky = 1'b0;
    chk("t5_sticky_pre", 32'(sticky_v), 32'd0);
    set_in(1'b1, 32'h0000_0005, 1'b0, 1'b1); cyc();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t5_sticky_set", 32'(sticky_v), 32'(STICKY_EXP));
    clr_sticky = 1'b1; cyc(); clr_sticky = 1'b0;
    chk("t5_sticky_clr", 32'(sticky_v), 32'd0);
    set_in(1'b1, 32'h0000_0006, 1'b0, 1'b1);
    clr_sticky = 1'b1; cyc(); clr_sticky = 1'b0;
    chk("t5_sticky_setwins", 32'(sticky_v), 32'(STICKY_EXP));
    set_in(1'b1, 32'h0000_0007, 1'b0, 1'b0); cyc();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t5_count3", 32'(count), 32'd3);

    // Mid-operation asynchronous reset
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_out_result", out_result, 32'd0);
    chk("t6_out_flags", 32'(out_flags), 32'd0);
    chk("t6_sticky", 32'(sticky_v), 32'd0);
    #12;
    rst_n = 1'b1;
    cyc();
    chk("t6_count_after", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
